// File: rtl/m_muldiv_defs.sv
// Shared RV32M multiply/divide definitions: funct3 op codes, FSM states, decode helpers.
package m_muldiv_defs;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // The controller uses this to raise the start strobe and forward funct3 as the op.
  function automatic logic is_muldiv(input logic [6:0] opcode, input logic [6:0] funct7);
    return (opcode == OPCODE_OP) && (funct7 == FUNCT7_MULDIV);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_signed_a(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_REM) || (op == OP_MULH) || (op == OP_MULHSU);
  endfunction

  function automatic logic op_signed_b(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_REM) || (op == OP_MULH);
  endfunction

endpackage

// File: rtl/m_divmul_step.sv
// One iteration on magnitudes: shift-add multiply (acc shifts right) or restoring divide
// (remainder:dividend shifts left). Purely combinational.
module m_divmul_step #(
  parameter int WIDTH = 32
) (
  input  logic               mode_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               cur_bit,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               q_bit
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] sub;
  logic             ge;

  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (cur_bit ? operand : {WIDTH{1'b0}})};
    rem_sh   = {acc[2*WIDTH-1:WIDTH], cur_bit};
    ge       = rem_sh >= {1'b0, operand};
    // When ge holds the true difference is below the divisor, so W bits suffice.
    sub      = rem_sh[WIDTH-1:0] - operand;
    acc_next = '0;
    q_bit    = 1'b0;
    if (mode_div) begin
      q_bit    = ge;
      acc_next = {(ge ? sub : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/m_muldiv_seq.sv
// Iterative RV32M multiply/divide: WIDTH+2 cycles per op (2 for divide special cases),
// valid/ready on both request and result; holds the result in DONE until i_ready.
module m_muldiv_seq
  import m_muldiv_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_busy
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         op_q;
  logic               sa_q, sb_q, spec_q;
  logic [WIDTH-1:0]   opd_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   result_q;

  logic               sa_in, sb_in, div_zero, div_ovf, special;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] step_acc, prod;
  logic               step_q;
  logic [WIDTH-1:0]   quo_f, rem_f, fix_result;

  always_comb begin
    sa_in    = op_signed_a(i_op) & i_a[WIDTH-1];
    sb_in    = op_signed_b(i_op) & i_b[WIDTH-1];
    mag_a    = sa_in ? -i_a : i_a;
    mag_b    = sb_in ? -i_b : i_b;
    div_zero = op_is_div(i_op) && (i_b == '0);
    div_ovf  = op_is_div(i_op) && !i_op[0] && (i_a == MIN_NEG) && (i_b == '1);
    special  = div_zero || div_ovf;
  end

  m_divmul_step #(.WIDTH(WIDTH)) u_step (
    .mode_div (op_q[2]),
    .acc      (acc_q),
    .operand  (opd_q),
    .cur_bit  (op_q[2] ? acc_q[WIDTH-1] : acc_q[0]),
    .acc_next (step_acc),
    .q_bit    (step_q)
  );

  // Special cases preload acc with the final {remainder, quotient} and bypass the sign fix.
  always_comb begin
    prod  = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo_f = acc_q[WIDTH-1:0];
    rem_f = acc_q[2*WIDTH-1:WIDTH];
    if (!spec_q) begin
      if (sa_q ^ sb_q) quo_f = -acc_q[WIDTH-1:0];
      if (sa_q)        rem_f = -acc_q[2*WIDTH-1:WIDTH];
    end
    case (op_q)
      OP_MUL:                      fix_result = prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:             fix_result = quo_f;
      default:                     fix_result = rem_f;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (i_valid) state_nxt = special ? S_FIX : S_CALC;
      S_CALC: if (cnt == CNT_W'(WIDTH-1)) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: if (i_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt      <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      spec_q   <= 1'b0;
      opd_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (i_valid) begin
          op_q   <= i_op;
          sa_q   <= sa_in;
          sb_q   <= sb_in;
          spec_q <= special;
          cnt    <= '0;
          opd_q  <= op_is_div(i_op) ? mag_b : mag_a;
          if (div_zero)             acc_q <= {i_a, {WIDTH{1'b1}}};
          else if (div_ovf)         acc_q <= {{WIDTH{1'b0}}, i_a};
          else if (op_is_div(i_op)) acc_q <= {{WIDTH{1'b0}}, mag_a};
          else                      acc_q <= {{WIDTH{1'b0}}, mag_b};
        end
        S_CALC: begin
          acc_q <= step_acc | {{(2*WIDTH-1){1'b0}}, step_q};
          cnt   <= cnt + 1'b1;
        end
        S_FIX:   result_q <= fix_result;
        default: ;
      endcase
    end
  end

  assign o_ready  = (state == S_IDLE);
  assign o_valid  = (state == S_DONE);
  assign o_busy   = (state == S_CALC) || (state == S_FIX);
  assign o_result = result_q;

endmodule

// File: tb/tb_m_muldiv_seq.sv
// Randomized and directed checks of m_muldiv_seq (WIDTH=32 and WIDTH=8) against an
// arithmetic reference model; a negedge monitor compares every valid result.
module tb_m_muldiv_seq;
  import m_muldiv_defs::*;

  logic        clk = 1'b0;
  logic        rst32, rst8, vld, w8, rdy;
  logic [2:0]  op;
  logic [31:0] a, b;

  logic        rdy32, val32, busy32;
  logic [31:0] res32;
  logic        rdy8, val8, busy8;
  logic [7:0]  res8;

  logic        s_valid, s_ready;
  logic [31:0] s_res;

  logic [31:0] q32[$];
  logic [31:0] q8[$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  m_muldiv_seq #(.WIDTH(32)) dut32 (
    .i_clk(clk), .i_reset(rst32), .i_valid(vld && !w8), .o_ready(rdy32),
    .i_op(op), .i_a(a), .i_b(b), .o_valid(val32), .i_ready(rdy),
    .o_result(res32), .o_busy(busy32)
  );

  m_muldiv_seq #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_reset(rst8), .i_valid(vld && w8), .o_ready(rdy8),
    .i_op(op), .i_a(a[7:0]), .i_b(b[7:0]), .o_valid(val8), .i_ready(rdy),
    .o_result(res8), .o_busy(busy8)
  );

  assign s_valid = w8 ? val8 : val32;
  assign s_ready = w8 ? rdy8 : rdy32;
  assign s_res   = w8 ? {24'b0, res8} : res32;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RV32M semantics on w-bit operands, using 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] aa,
                                        input logic [31:0] bb, input int w);
    logic [63:0] mask, ua, ub, sa, sb, p, r;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'b0, aa} & mask;
    ub   = {32'b0, bb} & mask;
    sa   = ua[w-1] ? (ua | ~mask) : ua;
    sb   = ub[w-1] ? (ub | ~mask) : ub;
    case (o)
      OP_MUL:    r = ua * ub;
      OP_MULH:   begin p = sa * sb; r = p >> w; end
      OP_MULHSU: begin p = sa * ub; r = p >> w; end
      OP_MULHU:  begin p = ua * ub; r = p >> w; end
      OP_DIV:    r = (ub == 0) ? mask : 64'($signed(sa) / $signed(sb));
      OP_DIVU:   r = (ub == 0) ? mask : ua / ub;
      OP_REM:    r = (ub == 0) ? ua : 64'($signed(sa) % $signed(sb));
      default:   r = (ub == 0) ? ua : ua % ub;
    endcase
    r = r & mask;
    return r[31:0];
  endfunction

  always @(negedge clk) begin
    if (!rst32 && val32) begin
      checks++;
      if (q32.size() == 0) begin
        errors++;
        $display("FAIL result32: got %0h with no request outstanding", res32);
      end else if (res32 !== q32[0]) begin
        errors++;
        $display("FAIL result32: got %0h expected %0h", res32, q32[0]);
      end
      if (rdy && q32.size() > 0) void'(q32.pop_front());
    end
    if (!rst8 && val8) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL result8: got %0h with no request outstanding", res8);
      end else if ({24'b0, res8} !== q8[0]) begin
        errors++;
        $display("FAIL result8: got %0h expected %0h", res8, q8[0]);
      end
      if (rdy && q8.size() > 0) void'(q8.pop_front());
    end
  end

  // Called at posedge+1 with the selected unit idle.
  task automatic do_op(input bit is8, input logic [2:0] o, input logic [31:0] aa,
                       input logic [31:0] bb, input int hold, input bit has_lit,
                       input logic [31:0] lit);
    int          w, lat, exp_lat;
    logic [63:0] mask, mn;
    logic [31:0] m, first;
    bit          spec;
    w    = is8 ? 8 : 32;
    mask = (64'd1 << w) - 64'd1;
    mn   = 64'd1 << (w - 1);
    aa   = aa & mask[31:0];
    bb   = bb & mask[31:0];
    m    = model(o, aa, bb, w);
    spec = o[2] && ((bb == 0) || (!o[0] && {32'b0, aa} == mn && {32'b0, bb} == mask));
    exp_lat = spec ? 2 : w + 2;
    w8 = is8; op = o; a = aa; b = bb; rdy = (hold == 0); vld = 1'b1;
    chk("ready_idle", {31'b0, s_ready}, 32'd1);
    @(posedge clk);
    if (is8) q8.push_back(m); else q32.push_back(m);
    #1;
    vld = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    lat = 1;
    while (!s_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    first = s_res;
    if (has_lit) chk("literal", first, lit);
    for (int i = 0; i < hold; i++) begin
      vld = 1'b1; op = 3'($urandom); a = $urandom; b = $urandom;
      @(posedge clk); #1;
      chk("hold_valid", {31'b0, s_valid}, 32'd1);
      chk("hold_ready", {31'b0, s_ready}, 32'd0);
      chk("hold_result", s_res, first);
    end
    vld = 1'b0; rdy = 1'b1;
    @(posedge clk); #1;
    chk("ready_after", {31'b0, s_ready}, 32'd1);
    chk("valid_after", {31'b0, s_valid}, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst32 = 1'b1; rst8 = 1'b1; vld = 1'b0; w8 = 1'b0; rdy = 1'b0;
    op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready32", {31'b0, rdy32}, 32'd1);
    chk("rst_valid32", {31'b0, val32}, 32'd0);
    chk("rst_busy32", {31'b0, busy32}, 32'd0);
    chk("rst_result32", res32, 32'd0);
    chk("rst_ready8", {31'b0, rdy8}, 32'd1);
    rst32 = 1'b0; rst8 = 1'b0;
    @(posedge clk); #1;

    do_op(0, OP_MUL,    32'd7,         32'hFFFF_FFFD, 0, 1, 32'hFFFF_FFEB);
    do_op(0, OP_MULH,   32'h8000_0000, 32'h8000_0000, 0, 1, 32'h4000_0000);
    do_op(0, OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 32'hFFFF_FFFE);
    do_op(0, OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 32'hFFFF_FFFF);
    do_op(0, OP_DIV,    32'hFFFF_FFF9, 32'd2,         0, 1, 32'hFFFF_FFFD);
    do_op(0, OP_REM,    32'hFFFF_FFF9, 32'd2,         0, 1, 32'hFFFF_FFFF);
    do_op(0, OP_DIVU,   32'hFFFF_FFF9, 32'd2,         0, 1, 32'h7FFF_FFFC);
    do_op(0, OP_REMU,   32'd100,       32'd7,         0, 1, 32'd2);
    do_op(0, OP_DIV,    32'd5,         32'd0,         0, 1, 32'hFFFF_FFFF);
    do_op(0, OP_REM,    32'd5,         32'd0,         0, 1, 32'd5);
    do_op(0, OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 32'h8000_0000);
    do_op(0, OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 0, 1, 32'd0);
    do_op(0, OP_MULH,   32'hFFFF_FFF9, 32'd3,        10, 1, 32'hFFFF_FFFF);

    do_op(1, OP_MUL,  32'd13,  32'd11, 0, 1, 32'h8F);
    do_op(1, OP_DIV,  32'h80,  32'hFF, 2, 1, 32'h80);

    // Abort an 8-bit multiply on its fifth CALC cycle.
    w8 = 1'b1; op = OP_MULHU; a = 32'hC3; b = 32'h5A; vld = 1'b1;
    @(posedge clk); #1;
    vld = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("busy_calc8", {31'b0, busy8}, 32'd1);
    rst8 = 1'b1;
    @(posedge clk); #1;
    rst8 = 1'b0;
    chk("abort_valid8", {31'b0, val8}, 32'd0);
    chk("abort_busy8", {31'b0, busy8}, 32'd0);
    chk("abort_ready8", {31'b0, rdy8}, 32'd1);
    chk("abort_result8", {24'b0, res8}, 32'd0);
    do_op(1, OP_DIVU, 32'd200, 32'd3, 0, 1, 32'd66);

    for (int n = 0; n < 40; n++) begin
      do_op(1'($urandom), 3'($urandom), pick(), pick(), $urandom_range(0, 3), 0, 32'd0);
    end

    chk("queue32_empty", 32'(q32.size()), 32'd0);
    chk("queue8_empty", 32'(q8.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
